// File: rtl/vga_timing_pkg.sv
// Shared timing types, mode constants and geometry helpers
// for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] display;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } vga_mode_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        h: '{16'd640, 16'd16, 16'd96, 16'd48},
        v: '{16'd480, 16'd10, 16'd2, 16'd33}
    };

    localparam vga_mode_t VGA_640x400_70 = '{
        h: '{16'd640, 16'd16, 16'd96, 16'd48},
        v: '{16'd400, 16'd12, 16'd2, 16'd35}
    };

    function automatic int unsigned total(timing_t t);
        return 32'(t.display) + 32'(t.front) + 32'(t.sync) + 32'(t.back);
    endfunction

    function automatic int unsigned sync_lo(timing_t t);
        return 32'(t.display) + 32'(t.front);
    endfunction

    function automatic int unsigned sync_hi(timing_t t);
        return 32'(t.display) + 32'(t.front) + 32'(t.sync);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One beam axis: position counter with wrap, plus sync and visible
// flags decoded from the position being loaded.
module vga_axis_counter #(
    parameter int   W        = 10,
    parameter logic RST_SYNC = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ce,
    input  logic         i_adv,
    input  logic [W-1:0] i_last,
    input  logic [W:0]   i_disp,
    input  logic [W:0]   i_sync_lo,
    input  logic [W:0]   i_sync_hi,
    input  logic         i_pol,
    output logic [W-1:0] o_pos,
    output logic         o_sync,
    output logic         o_vis
);

    logic [W-1:0] r_pos;
    logic         r_sync;
    logic         r_vis;
    logic [W-1:0] w_next;
    logic [W:0]   w_next_x;
    logic         w_in_sync;

    always_comb begin
        w_next = r_pos;
        if (i_adv) begin
            w_next = (r_pos == i_last) ? '0 : r_pos + 1'b1;
        end
    end

    assign w_next_x  = {1'b0, w_next};
    assign w_in_sync = (w_next_x >= i_sync_lo) && (w_next_x < i_sync_hi);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos  <= '0;
            r_sync <= RST_SYNC;
            r_vis  <= 1'b0;
        end else if (i_ce) begin
            r_pos  <= w_next;
            r_sync <= w_in_sync ? i_pol : ~i_pol;
            r_vis  <= (w_next_x < i_disp);
        end
    end

    assign o_pos  = r_pos;
    assign o_sync = r_sync;
    assign o_vis  = r_vis;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with two selectable timing sets,
// switched only at frame boundaries.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter timing_t H_A     = VGA_640x480_60.h,
    parameter timing_t V_A     = VGA_640x480_60.v,
    parameter timing_t H_B     = VGA_640x400_70.h,
    parameter timing_t V_B     = VGA_640x400_70.v,
    parameter logic    HPOL_A  = 1'b0,
    parameter logic    VPOL_A  = 1'b0,
    parameter logic    HPOL_B  = 1'b0,
    parameter logic    VPOL_B  = 1'b1,
    parameter int      FRAME_W = 12,
    parameter int      HW      = 10,
    parameter int      VW      = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               mode_sel,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic               mode_active
);

    localparam int unsigned HT_A = total(H_A);
    localparam int unsigned VT_A = total(V_A);
    localparam int unsigned HT_B = total(H_B);
    localparam int unsigned VT_B = total(V_B);

    if (HT_A > 2**HW || HT_B > 2**HW || VT_A > 2**VW || VT_B > 2**VW) begin : g_bad_width
        $error("vga_timing_gen: timing total exceeds position width");
    end

    logic               r_mode;
    logic               r_ls;
    logic               r_fs;
    logic [FRAME_W-1:0] r_fc;

    logic          w_mode_nxt;
    logic          w_h_wrap;
    logic          w_f_wrap;
    logic [HW-1:0] w_h_last;
    logic [VW-1:0] w_v_last;
    timing_t       w_hn;
    timing_t       w_vn;
    logic          w_hpol;
    logic          w_vpol;
    logic          w_h_vis;
    logic          w_v_vis;

    // Wrap uses the set in force; decodes use the set the wrap loads.
    assign w_h_last   = r_mode ? HW'(HT_B - 1) : HW'(HT_A - 1);
    assign w_v_last   = r_mode ? VW'(VT_B - 1) : VW'(VT_A - 1);
    assign w_h_wrap   = (hpos == w_h_last);
    assign w_f_wrap   = w_h_wrap && (vpos == w_v_last);
    assign w_mode_nxt = w_f_wrap ? mode_sel : r_mode;

    assign w_hn   = w_mode_nxt ? H_B : H_A;
    assign w_vn   = w_mode_nxt ? V_B : V_A;
    assign w_hpol = w_mode_nxt ? HPOL_B : HPOL_A;
    assign w_vpol = w_mode_nxt ? VPOL_B : VPOL_A;

    vga_axis_counter #(.W(HW), .RST_SYNC(~HPOL_A)) u_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ce      (ce),
        .i_adv     (1'b1),
        .i_last    (w_h_last),
        .i_disp    ((HW+1)'(w_hn.display)),
        .i_sync_lo ((HW+1)'(sync_lo(w_hn))),
        .i_sync_hi ((HW+1)'(sync_hi(w_hn))),
        .i_pol     (w_hpol),
        .o_pos     (hpos),
        .o_sync    (hsync),
        .o_vis     (w_h_vis)
    );

    vga_axis_counter #(.W(VW), .RST_SYNC(~VPOL_A)) u_v (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ce      (ce),
        .i_adv     (w_h_wrap),
        .i_last    (w_v_last),
        .i_disp    ((VW+1)'(w_vn.display)),
        .i_sync_lo ((VW+1)'(sync_lo(w_vn))),
        .i_sync_hi ((VW+1)'(sync_hi(w_vn))),
        .i_pol     (w_vpol),
        .o_pos     (vpos),
        .o_sync    (vsync),
        .o_vis     (w_v_vis)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
            r_fc   <= '0;
        end else begin
            r_ls <= ce & w_h_wrap;
            r_fs <= ce & w_f_wrap;
            if (ce) begin
                r_mode <= w_mode_nxt;
                if (w_f_wrap) begin
                    r_fc <= r_fc + 1'b1;
                end
            end
        end
    end

    assign display_on  = w_h_vis & w_v_vis;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_count = r_fc;
    assign mode_active = r_mode;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster
// (15 x 11 set A, 15 x 9 set B) and a 2-bit frame counter.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam timing_t TH  = '{16'd8, 16'd2, 16'd3, 16'd2};
    localparam timing_t TVA = '{16'd6, 16'd1, 16'd2, 16'd2};
    localparam timing_t TVB = '{16'd4, 16'd1, 16'd1, 16'd3};

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [1:0] fc;
        logic       ma;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       mode_sel = 1'b0;
    logic [3:0] hpos;
    logic [3:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic [1:0] frame_count;
    logic       mode_active;

    int   n_chk = 0;
    int   n_err = 0;
    obs_t q[$];
    int   m_h, m_v, m_fc;
    bit   m_ma;
    obs_t m_o;
    bit   sel = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_A(TH), .V_A(TVA), .H_B(TH), .V_B(TVB),
        .HPOL_A(1'b0), .VPOL_A(1'b0), .HPOL_B(1'b0), .VPOL_B(1'b1),
        .FRAME_W(2), .HW(4), .VW(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .mode_sel(mode_sel),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .line_start(line_start),
        .frame_start(frame_start), .frame_count(frame_count),
        .mode_active(mode_active)
    );

    function automatic int vtot(bit b);
        return b ? 9 : 11;
    endfunction

    task automatic model(input bit r, input bit c, input bit ms);
        if (!r) begin
            m_h = 0; m_v = 0; m_fc = 0; m_ma = 0;
            m_o = '{h:4'd0, v:4'd0, hs:1'b1, vs:1'b1, de:1'b0,
                    ls:1'b0, fs:1'b0, fc:2'd0, ma:1'b0};
            return;
        end
        m_o.ls = 1'b0;
        m_o.fs = 1'b0;
        if (!c) return;
        if (m_h == 14) begin
            m_h = 0;
            m_o.ls = 1'b1;
            if (m_v == vtot(m_ma) - 1) begin
                m_v = 0;
                m_o.fs = 1'b1;
                m_fc = (m_fc + 1) % 4;
                m_ma = ms;
            end else begin
                m_v++;
            end
        end else begin
            m_h++;
        end
        m_o.h  = 4'(m_h);
        m_o.v  = 4'(m_v);
        m_o.fc = 2'(m_fc);
        m_o.ma = m_ma;
        m_o.hs = (m_h >= 10 && m_h <= 12) ? 1'b0 : 1'b1;
        if (m_ma) m_o.vs = (m_v == 5) ? 1'b1 : 1'b0;
        else      m_o.vs = (m_v >= 7 && m_v <= 8) ? 1'b0 : 1'b1;
        m_o.de = (m_h < 8) && (m_v < (m_ma ? 4 : 6));
    endtask

    task automatic step(input bit c, input bit r, input string tag);
        obs_t e, a;
        @(negedge clk);
        ce = c; rst_n = r; mode_sel = sel;
        model(r, c, sel);
        q.push_back(m_o);
        @(posedge clk);
        #1;
        cyc++;
        e = q.pop_front();
        a = '{h:hpos, v:vpos, hs:hsync, vs:vsync, de:display_on,
              ls:line_start, fs:frame_start, fc:frame_count, ma:mode_active};
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, a, e);
        end
    endtask

    task automatic do_reset();
        sel = 0;
        step(1'b1, 1'b0, "reset");
        step(1'b0, 1'b1, "reset_rel");
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        for (int i = 0; i < 400 && !(m_h == h && m_v == v); i++)
            step(1'b1, 1'b1, tag);
        n_chk++;
        if (!(m_h == h && m_v == v)) begin
            n_err++;
            $display("FAIL %s: position not reached got %0d,%0d want %0d,%0d",
                     tag, m_h, m_v, h, v);
        end
    endtask

    task automatic test_reset();
        sel = 1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_ovr");
        sel = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "reset_hold");
        step(1'b1, 1'b1, "first_ce");
        n_chk++;
        if (hpos !== 4'd1 || vpos !== 4'd0 || display_on !== 1'b1) begin
            n_err++;
            $display("FAIL first_ce_pos: got %0d,%0d de=%b want 1,0 de=1",
                     hpos, vpos, display_on);
        end
    endtask

    task automatic test_frames();
        int fs_n, fs_t0, fs_t1, hs_lo, hs_bad;
        do_reset();
        fs_n = 0; fs_t0 = 0; fs_t1 = 0; hs_lo = 0; hs_bad = 0;
        for (int i = 0; i < 330; i++) begin
            step(1'b1, 1'b1, "frames");
            if (frame_start) begin
                if (fs_n == 0) fs_t0 = cyc; else fs_t1 = cyc;
                fs_n++;
            end
            if (hsync === 1'b0) begin
                hs_lo++;
                if (hpos < 4'd10 || hpos > 4'd12) hs_bad++;
            end
        end
        n_chk++;
        if (fs_n != 2 || fs_t1 - fs_t0 != 165) begin
            n_err++;
            $display("FAIL frames_fs: got n=%0d gap=%0d want n=2 gap=165",
                     fs_n, fs_t1 - fs_t0);
        end
        n_chk++;
        if (frame_count !== 2'd2) begin
            n_err++;
            $display("FAIL frames_fc: got %0d want 2", frame_count);
        end
        n_chk++;
        if (hs_lo != 66 || hs_bad != 0) begin
            n_err++;
            $display("FAIL frames_hsync: got low=%0d bad=%0d want 66,0",
                     hs_lo, hs_bad);
        end
    endtask

    task automatic test_half_rate();
        int fs_n, fs_t0, fs_t1;
        do_reset();
        fs_n = 0; fs_t0 = 0; fs_t1 = 0;
        for (int i = 0; i < 330; i++) begin
            step(1'b1, 1'b1, "half_ce1");
            if (frame_start) begin
                if (fs_n == 0) fs_t0 = cyc; else fs_t1 = cyc;
                fs_n++;
            end
            step(1'b0, 1'b1, "half_ce0");
        end
        n_chk++;
        if (fs_n != 2 || fs_t1 - fs_t0 != 330) begin
            n_err++;
            $display("FAIL half_fs: got n=%0d gap=%0d want n=2 gap=330",
                     fs_n, fs_t1 - fs_t0);
        end
    endtask

    task automatic test_mode_switch();
        int t0, t1, vs_hi;
        do_reset();
        run_to(0, 3, "sw_pre");
        sel = 1;
        run_to(14, 10, "sw_wait");
        n_chk++;
        if (mode_active !== 1'b0) begin
            n_err++;
            $display("FAIL sw_early: got %b want 0", mode_active);
        end
        step(1'b1, 1'b1, "sw_wrap");
        t0 = cyc;
        n_chk++;
        if (mode_active !== 1'b1 || frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL sw_apply: got ma=%b fs=%b want 1,1",
                     mode_active, frame_start);
        end
        vs_hi = 0; t1 = 0;
        for (int i = 0; i < 135 && t1 == 0; i++) begin
            step(1'b1, 1'b1, "sw_frameB");
            if (vsync === 1'b1) vs_hi++;
            if (frame_start) t1 = cyc;
        end
        n_chk++;
        if (t1 - t0 != 135 || vs_hi != 15) begin
            n_err++;
            $display("FAIL sw_geom: got gap=%0d vs_hi=%0d want 135,15",
                     t1 - t0, vs_hi);
        end
        for (int i = 0; i < 500; i++) begin
            sel = 1'($urandom_range(0, 1));
            step(1'b1, 1'b1, "sw_random");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(6, 4, "mid_pre");
        sel = 1;
        step(1'b1, 1'b0, "mid_rst");
        sel = 0;
        step(1'b0, 1'b1, "mid_hold");
        n_chk++;
        if (hpos !== 4'd0 || frame_count !== 2'd0 || hsync !== 1'b1
            || vsync !== 1'b1 || line_start !== 1'b0) begin
            n_err++;
            $display("FAIL mid_state: got h=%0d fc=%0d hs=%b vs=%b ls=%b want 0,0,1,1,0",
                     hpos, frame_count, hsync, vsync, line_start);
        end
    endtask

    task automatic test_fc_wrap();
        logic [1:0] seq[$];
        logic [1:0] want[5];
        want = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int i = 0; i < 825; i++) begin
            step(1'b1, 1'b1, "fcw");
            if (frame_start) seq.push_back(frame_count);
        end
        n_chk++;
        if (seq.size() != 5) begin
            n_err++;
            $display("FAIL fcw_count: got %0d want 5", seq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (seq[i] !== want[i]) begin
                    n_err++;
                    $display("FAIL fcw_seq[%0d]: got %0d want %0d",
                             i, seq[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_ce_hold();
        int pulses;
        do_reset();
        run_to(14, 10, "hold_pre");
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b1, "hold");
            if (frame_start || line_start) pulses++;
        end
        n_chk++;
        if (pulses != 0 || hpos !== 4'd14 || vpos !== 4'd10) begin
            n_err++;
            $display("FAIL hold_state: got p=%0d pos=%0d,%0d want 0,14,10",
                     pulses, hpos, vpos);
        end
        step(1'b1, 1'b1, "hold_go");
        n_chk++;
        if (frame_start !== 1'b1 || hpos !== 4'd0 || vpos !== 4'd0) begin
            n_err++;
            $display("FAIL hold_wrap: got fs=%b pos=%0d,%0d want 1,0,0",
                     frame_start, hpos, vpos);
        end
        step(1'b0, 1'b1, "hold_after");
    endtask

    initial begin
        test_reset();
        test_frames();
        test_half_rate();
        test_mode_switch();
        test_reset_mid();
        test_fc_wrap();
        test_ce_hold();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
